// File: rtl/tdpr_pkg.sv
// Shared defaults and the wrapping pointer increment used by the TDPR FIFO controller.
package tdpr_pkg;

    localparam int TDPR_ADDR_SIZE = 8;
    localparam int TDPR_DATA_SIZE = 8;

    // Advance a RAM pointer, wrapping at the (possibly non-power-of-two) depth.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned size);
        return (ptr == size - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/tdpr_obuf.sv
// Two-entry FIFO-ordered output buffer; the head word is held in a register and drives o_data directly.
module tdpr_obuf #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cap,
    input  logic [DATA_SIZE-1:0] i_cap_data,
    input  logic                 i_pop,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    output logic [1:0]           o_cnt
);

    logic [DATA_SIZE-1:0] r_head;
    logic [DATA_SIZE-1:0] r_tail;
    logic [1:0]           r_cnt;
    logic                 w_pop;

    assign w_pop = i_pop && (r_cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({i_cap, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= i_cap_data;
                    end else begin
                        r_tail <= i_cap_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (r_cnt == 2'd1) begin
                        r_head <= i_cap_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_cnt != 2'd0);
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/tdpr_fifo_ctrl.sv
// FIFO controller driving an external true-dual-port RAM (A = write, B = read) with a 2-word output buffer.
// Optional almost_full/almost_empty flags are built when TDPR_FIFO_ALMOST_EN is defined.
module tdpr_fifo_ctrl
    import tdpr_pkg::*;
#(
    parameter int ADDR_SIZE = TDPR_ADDR_SIZE,
    parameter int DATA_SIZE = TDPR_DATA_SIZE,
    parameter int RAM_SIZE  = 1 << ADDR_SIZE
`ifdef TDPR_FIFO_ALMOST_EN
    ,
    parameter int AF_THRESH = RAM_SIZE - 2,
    parameter int AE_THRESH = 2
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 en_a,
    output logic                 we_a,
    output logic [ADDR_SIZE-1:0] addr_a,
    output logic [DATA_SIZE-1:0] din_a,
    output logic                 en_b,
    output logic                 we_b,
    output logic [ADDR_SIZE-1:0] addr_b,
    input  logic [DATA_SIZE-1:0] dout_b,
    output logic [ADDR_SIZE+1:0] level
`ifdef TDPR_FIFO_ALMOST_EN
    ,
    output logic                 almost_full,
    output logic                 almost_empty
`endif
);

    typedef logic [ADDR_SIZE-1:0] ptr_t;
    typedef logic [ADDR_SIZE:0]   cnt_t;
    typedef logic [ADDR_SIZE+1:0] lvl_t;

    localparam cnt_t LP_RAM_SIZE = cnt_t'(RAM_SIZE);

    ptr_t       r_wptr;
    ptr_t       r_rptr;
    cnt_t       r_ram_cnt;
    logic       r_inflight;
    logic       w_push;
    logic       w_pop;
    logic       w_rd_issue;
    logic [1:0] w_obuf_cnt;
    logic [2:0] w_slots_used;

    assign wr_ready = (r_ram_cnt < LP_RAM_SIZE);
    // Held off while reset is asserted so port A stays idle even if the producer keeps wr_valid high.
    assign w_push   = wr_valid && wr_ready && rst_n;
    assign w_pop    = rd_valid && rd_ready;

    // A pop in the same cycle frees an output slot, which keeps streaming at one word per clock.
    assign w_slots_used = {1'b0, w_obuf_cnt} + {2'b00, r_inflight};
    assign w_rd_issue   = (r_ram_cnt != '0) && (w_slots_used < (3'd2 + {2'b00, w_pop}));

    assign en_a   = w_push;
    assign we_a   = w_push;
    assign addr_a = r_wptr;
    assign din_a  = wr_data;
    assign en_b   = w_rd_issue;
    assign we_b   = 1'b0;
    assign addr_b = r_rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_t'(ptr_inc(32'(r_wptr), RAM_SIZE));
            end
            if (w_rd_issue) begin
                r_rptr <= ptr_t'(ptr_inc(32'(r_rptr), RAM_SIZE));
            end
            case ({w_push, w_rd_issue})
                2'b10:   r_ram_cnt <= r_ram_cnt + cnt_t'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - cnt_t'(1);
                default: ;
            endcase
            r_inflight <= w_rd_issue;
        end
    end

    tdpr_obuf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_obuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cap      (r_inflight),
        .i_cap_data (dout_b),
        .i_pop      (w_pop),
        .o_data     (rd_data),
        .o_valid    (rd_valid),
        .o_cnt      (w_obuf_cnt)
    );

    assign level = lvl_t'(r_ram_cnt) + lvl_t'(r_inflight) + lvl_t'(w_obuf_cnt);

`ifdef TDPR_FIFO_ALMOST_EN
    lvl_t w_level_next;
    logic r_almost_full;
    logic r_almost_empty;

    // Moves between RAM, flight and buffer keep the total; only push and pop change it.
    assign w_level_next = level + lvl_t'(w_push) - lvl_t'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_level_next >= lvl_t'(AF_THRESH));
            r_almost_empty <= (w_level_next <= lvl_t'(AE_THRESH));
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

endmodule
